// File: rtl/csi2tx_p2b_seq_pkg.sv
// -----------------------------------------------------------------------------
// csi2tx_p2b_seq_pkg
// Shared definitions for the CSI-2 TX pixel-to-byte sequencer:
//   - CSI-2 data type codes handled by the p2b converters
//   - bytes-per-pixel constants for each supported type
//   - sequencer state encoding and the one-hot converter enable struct
//   - data type decode and bytes-per-pixel helper functions
// -----------------------------------------------------------------------------
package csi2tx_p2b_seq_pkg;

    // CSI-2 data type codes
    localparam logic [5:0] DT_YUV422_8B = 6'h1E;
    localparam logic [5:0] DT_RGB888    = 6'h24;
    localparam logic [5:0] DT_RAW8      = 6'h2A;

    // Payload bytes produced per pixel
    localparam logic [1:0] BPP_YUV422_8B = 2'd2;
    localparam logic [1:0] BPP_RGB888    = 2'd3;
    localparam logic [1:0] BPP_RAW8      = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic yuv4228b;
        logic rgb888;
        logic raw8;
    } conv_en_t;

    // One-hot converter enable for a data type; all zero when unsupported.
    function automatic conv_en_t dt_decode(input logic [5:0] dt);
        conv_en_t en;
        en = '0;
        case (dt)
            DT_YUV422_8B: en.yuv4228b = 1'b1;
            DT_RGB888:    en.rgb888   = 1'b1;
            DT_RAW8:      en.raw8     = 1'b1;
            default:      en          = '0;
        endcase
        return en;
    endfunction

    // Bytes per pixel for the currently enabled converter.
    function automatic logic [1:0] bytes_per_pixel(input conv_en_t en);
        logic [1:0] bpp;
        bpp = '0;
        if (en.yuv4228b) begin
            bpp = BPP_YUV422_8B;
        end else if (en.rgb888) begin
            bpp = BPP_RGB888;
        end else if (en.raw8) begin
            bpp = BPP_RAW8;
        end
        return bpp;
    endfunction

endpackage

// File: rtl/csi2tx_p2b_edge_det.sv
// -----------------------------------------------------------------------------
// csi2tx_p2b_edge_det
// Registered rise/fall detector for the sensor pixel strobe.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : strobe being watched
//   dly        : din delayed by one clock (registered copy)
//   rise       : din high now, low last cycle
//   fall       : din low now, high last cycle
// -----------------------------------------------------------------------------
module csi2tx_p2b_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dly,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= 1'b0;
        end else begin
            dly <= din;
        end
    end

    assign rise = din & ~dly;
    assign fall = ~din & dly;

endmodule

// File: rtl/csi2tx_p2b_seq.sv
// -----------------------------------------------------------------------------
// csi2tx_p2b_seq
// Sequencer in front of the CSI-2 TX pixel-to-byte converters. Registers the
// sensor pixel stream, indexes pixels mod 4, decodes the line data type into
// one-hot converter enables, flags end of line and checks the produced byte
// count against the programmed word count.
//
// Build option: define CSI2TX_P2B_WC_CHECK_EN to build the byte counter and
// word count comparator; without it wc_err is tied low.
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   sensor_pixel_vld/_data         : sensor pixel strobe and pixel
//   data_type                      : CSI-2 data type, sampled at line start
//   word_count                     : expected payload bytes for the line
//   pixel_data, pixel_data_vld     : registered pixel and gated strobe
//   pixel_cnt                      : index mod 4 of the pixel on pixel_data
//   sensor_pixel_vld_falling_edge  : one-cycle end-of-line pulse
//   *_convrn_enable                : one-hot converter enables
//   line_done                      : one-cycle pulse after flush
//   dt_err                         : unsupported data type at line start
//   wc_err                         : byte count mismatch, with line_done
// -----------------------------------------------------------------------------
module csi2tx_p2b_seq
    import csi2tx_p2b_seq_pkg::*;
#(
    parameter int unsigned WC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sensor_pixel_vld,
    input  logic [31:0]     sensor_pixel_data,
    input  logic [5:0]      data_type,
    input  logic [WC_W-1:0] word_count,
    output logic [31:0]     pixel_data,
    output logic            pixel_data_vld,
    output logic [1:0]      pixel_cnt,
    output logic            sensor_pixel_vld_falling_edge,
    output logic            yuv4228b_convrn_enable,
    output logic            rgb888_convrn_enable,
    output logic            raw8_convrn_enable,
    output logic            line_done,
    output logic            dt_err,
    output logic            wc_err
);

    state_t   state;
    state_t   next_state;
    conv_en_t dt_en;
    conv_en_t en_q;
    logic     dt_ok;
    logic     vld_q;
    logic     vld_rise;
    logic     vld_fall;
    logic     restart;
    logic     in_line;
    logic     start_try;
    logic     line_start;
    logic     flush;
    logic     beat;

    csi2tx_p2b_edge_det u_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sensor_pixel_vld),
        .dly   (vld_q),
        .rise  (vld_rise),
        .fall  (vld_fall)
    );

    assign dt_en = dt_decode(data_type);
    assign dt_ok = |dt_en;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // A line that starts during FLUSH lands in IDLE with 'restart' set. That
    // IDLE cycle already carries the new line's first pixel, so it streams
    // like ACTIVE and may even end the line straight away (1-pixel line).
    // ---------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (restart) begin
                    next_state = sensor_pixel_vld ? ST_ACTIVE : ST_FLUSH;
                end else if (vld_rise && dt_ok) begin
                    next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!sensor_pixel_vld) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output / control decode
    // ---------------------------------------------------------------------
    always_comb begin
        in_line    = (state == ST_ACTIVE) || ((state == ST_IDLE) && restart);
        start_try  = vld_rise &&
                     (((state == ST_IDLE) && !restart) || (state == ST_FLUSH));
        line_start = start_try && dt_ok;
        flush      = (state == ST_FLUSH);
        beat       = in_line && vld_q;
    end

    assign pixel_data_vld = beat;

    assign yuv4228b_convrn_enable = en_q.yuv4228b;
    assign rgb888_convrn_enable   = en_q.rgb888;
    assign raw8_convrn_enable     = en_q.raw8;

    // ---------------------------------------------------------------------
    // Registered datapath and pulses
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data                    <= '0;
            restart                       <= 1'b0;
            sensor_pixel_vld_falling_edge <= 1'b0;
            line_done                     <= 1'b0;
            dt_err                        <= 1'b0;
            en_q                          <= '0;
            pixel_cnt                     <= '0;
        end else begin
            // Input register samples unconditionally so a pixel arriving in
            // the FLUSH cycle is still available on the following cycle.
            pixel_data                    <= sensor_pixel_data;
            restart                       <= flush && line_start;
            sensor_pixel_vld_falling_edge <= in_line && vld_fall;
            line_done                     <= flush;
            dt_err                        <= start_try && !dt_ok;

            if (line_start) begin
                en_q      <= dt_en;
                pixel_cnt <= '0;
            end else if (flush) begin
                en_q      <= '0;
                pixel_cnt <= '0;
            end else if (beat) begin
                pixel_cnt <= pixel_cnt + 2'd1;
            end
        end
    end

`ifdef CSI2TX_P2B_WC_CHECK_EN
    localparam int unsigned SUM_W = WC_W + 1;

    logic [WC_W-1:0]  byte_cnt;
    logic [SUM_W-1:0] byte_sum;

    assign byte_sum = {1'b0, byte_cnt} + SUM_W'(bytes_per_pixel(en_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            wc_err   <= 1'b0;
        end else begin
            // Compare uses the finished line's count even when a new line
            // starts in the same FLUSH cycle and clears the counter.
            wc_err <= flush && (byte_cnt != word_count);
            if (line_start || flush) begin
                byte_cnt <= '0;
            end else if (beat) begin
                byte_cnt <= byte_sum[WC_W] ? '1 : byte_sum[WC_W-1:0];
            end
        end
    end
`else
    logic unused_word_count;

    assign unused_word_count = ^word_count;
    assign wc_err            = 1'b0;
`endif

endmodule

// File: tb/tb_csi2tx_p2b_seq.sv
// -----------------------------------------------------------------------------
// tb_csi2tx_p2b_seq
// Self-checking bench for csi2tx_p2b_seq. Lines are described at line level
// (type, pixel count, word count, gap); expected outputs are derived from
// those descriptions with cycle arithmetic and compared every cycle.
// -----------------------------------------------------------------------------
module tb_csi2tx_p2b_seq;

    localparam int WC_W = 16;
    localparam int MAXC = 32768;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sensor_pixel_vld = 1'b0;
    logic [31:0]     sensor_pixel_data = '0;
    logic [5:0]      data_type = '0;
    logic [WC_W-1:0] word_count = '0;
    logic [31:0]     pixel_data;
    logic            pixel_data_vld;
    logic [1:0]      pixel_cnt;
    logic            sensor_pixel_vld_falling_edge;
    logic            yuv4228b_convrn_enable;
    logic            rgb888_convrn_enable;
    logic            raw8_convrn_enable;
    logic            line_done;
    logic            dt_err;
    logic            wc_err;

    always #5 clk = ~clk;

    csi2tx_p2b_seq #(.WC_W(WC_W)) dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .sensor_pixel_vld              (sensor_pixel_vld),
        .sensor_pixel_data             (sensor_pixel_data),
        .data_type                     (data_type),
        .word_count                    (word_count),
        .pixel_data                    (pixel_data),
        .pixel_data_vld                (pixel_data_vld),
        .pixel_cnt                     (pixel_cnt),
        .sensor_pixel_vld_falling_edge (sensor_pixel_vld_falling_edge),
        .yuv4228b_convrn_enable        (yuv4228b_convrn_enable),
        .rgb888_convrn_enable          (rgb888_convrn_enable),
        .raw8_convrn_enable            (raw8_convrn_enable),
        .line_done                     (line_done),
        .dt_err                        (dt_err),
        .wc_err                        (wc_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0] dt;
        int         npix;
        int         wc;
        int         gap;
    } line_t;

    line_t lines[$];

    // per-cycle stimulus and expectations (index = posedge number in a run)
    logic        in_vld   [MAXC];
    logic [31:0] in_data  [MAXC];
    logic [5:0]  in_dt    [MAXC];
    logic [15:0] in_wc    [MAXC];
    logic        exp_vld  [MAXC];
    logic [31:0] exp_data [MAXC];
    logic [1:0]  exp_cnt  [MAXC];
    logic [2:0]  exp_en   [MAXC];
    logic        exp_fall [MAXC];
    logic        exp_done [MAXC];
    logic        exp_dte  [MAXC];
    logic        exp_wce  [MAXC];
    int          ncyc;

    function automatic int bpp_of(input logic [5:0] dt);
        case (dt)
            6'h1E:   return 2;
            6'h24:   return 3;
            6'h2A:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] en_of(input logic [5:0] dt);
        return {dt == 6'h1E, dt == 6'h24, dt == 6'h2A};
    endfunction

    task automatic build();
        int c;
        int s;
        int nb;
        for (int i = 0; i < MAXC; i++) begin
            in_vld[i] = 0; in_data[i] = '0; in_dt[i] = '0; in_wc[i] = '0;
            exp_vld[i] = 0; exp_data[i] = '0; exp_cnt[i] = '0; exp_en[i] = '0;
            exp_fall[i] = 0; exp_done[i] = 0; exp_dte[i] = 0; exp_wce[i] = 0;
        end
        c = 2;
        foreach (lines[li]) begin
            s = c;
            for (int k = s; k < s + lines[li].npix + lines[li].gap; k++)
                in_dt[k] = lines[li].dt;
            for (int k = s + 1; k <= s + lines[li].npix + lines[li].gap; k++)
                in_wc[k] = 16'(lines[li].wc);
            for (int i = 0; i < lines[li].npix; i++) begin
                in_vld[s + i]  = 1'b1;
                in_data[s + i] = $urandom;
            end
            if (bpp_of(lines[li].dt) != 0) begin
                for (int i = 0; i < lines[li].npix; i++) begin
                    exp_vld[s + i]  = 1'b1;
                    exp_data[s + i] = in_data[s + i];
                    exp_cnt[s + i]  = 2'(i % 4);
                end
                for (int k = s; k <= s + lines[li].npix; k++)
                    exp_en[k] = en_of(lines[li].dt);
                exp_fall[s + lines[li].npix] = 1'b1;
                exp_cnt[s + lines[li].npix]  = 2'(lines[li].npix % 4);
                exp_done[s + lines[li].npix + 1] = 1'b1;
                nb = lines[li].npix * bpp_of(lines[li].dt);
                if (nb > 65535) nb = 65535;
`ifdef CSI2TX_P2B_WC_CHECK_EN
                exp_wce[s + lines[li].npix + 1] = (nb != lines[li].wc);
`else
                exp_wce[s + lines[li].npix + 1] = 1'b0;
`endif
            end else begin
                exp_dte[s] = 1'b1;
            end
            c = s + lines[li].npix + lines[li].gap;
        end
        ncyc = c + 4;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic play();
        for (int c = 0; c < ncyc; c++) begin
            sensor_pixel_vld  = in_vld[c];
            sensor_pixel_data = in_data[c];
            data_type         = in_dt[c];
            word_count        = in_wc[c];
            @(posedge clk);
            @(negedge clk);
            check("pixel_data_vld", 32'(pixel_data_vld), 32'(exp_vld[c]));
            if (exp_vld[c]) begin
                check("pixel_data", pixel_data, exp_data[c]);
                check("pixel_cnt", 32'(pixel_cnt), 32'(exp_cnt[c]));
            end
            if (exp_fall[c])
                check("pixel_cnt_at_fall", 32'(pixel_cnt), 32'(exp_cnt[c]));
            check("falling_edge", 32'(sensor_pixel_vld_falling_edge), 32'(exp_fall[c]));
            check("enables", 32'({yuv4228b_convrn_enable, rgb888_convrn_enable,
                                  raw8_convrn_enable}), 32'(exp_en[c]));
            check("line_done", 32'(line_done), 32'(exp_done[c]));
            check("dt_err", 32'(dt_err), 32'(exp_dte[c]));
            check("wc_err", 32'(wc_err), 32'(exp_wce[c]));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, pixel_data, 32'h0);
        check({tag, "_flags"}, 32'({pixel_data_vld, pixel_cnt, sensor_pixel_vld_falling_edge,
                                    yuv4228b_convrn_enable, rgb888_convrn_enable,
                                    raw8_convrn_enable, line_done, dt_err, wc_err}), 32'h0);
    endtask

    task automatic add_line(input logic [5:0] dt, input int npix, input int wc, input int gap);
        line_t l;
        l.dt = dt; l.npix = npix; l.wc = wc; l.gap = gap;
        lines.push_back(l);
    endtask

    initial begin
        int sel;
        int np;
        int wc;
        logic [5:0] dt;

        // reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // directed lines
        add_line(6'h1E, 4, 8, 2);
        add_line(6'h24, 5, 15, 2);
        add_line(6'h24, 5, 16, 2);
        add_line(6'h2B, 3, 0, 2);
        add_line(6'h2A, 3, 3, 1);       // next line starts in FLUSH
        add_line(6'h1E, 4, 8, 1);
        add_line(6'h2A, 1, 1, 1);       // 1-pixel line started in FLUSH
        add_line(6'h24, 1, 3, 2);

        // random lines
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1:    dt = 6'h1E;
                2, 3:    dt = 6'h24;
                4, 5, 7: dt = 6'h2A;
                default: begin
                    dt = 6'($urandom_range(0, 63));
                    while (bpp_of(dt) != 0) dt = 6'($urandom_range(0, 63));
                end
            endcase
            np = $urandom_range(1, 12);
            wc = np * bpp_of(dt);
            case ($urandom_range(0, 3))
                0:       wc = (wc > 0) ? wc - 1 : wc + 2;
                1:       wc = wc + 1;
                default: wc = wc;
            endcase
            add_line(dt, np, wc, $urandom_range(1, 3));
        end

        // byte counter saturation: 21846 * 3 = 65538 clamps to 65535
        add_line(6'h24, 21846, 65535, 3);

        build();
        play();

        // reset in the middle of a line
        sensor_pixel_vld = 1'b1;
        data_type        = 6'h2A;
        word_count       = 16'd100;
        for (int i = 0; i < 3; i++) begin
            sensor_pixel_data = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_line_vld", 32'(pixel_data_vld), 32'h1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_next_cycle");
        sensor_pixel_vld = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("no_done_after_reset", 32'(line_done), 32'h0);
        end

        // fresh line after reset
        lines.delete();
        add_line(6'h2A, 2, 2, 2);
        add_line(6'h2A, 3, 4, 2);       // mismatched word count
        build();
        play();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
